rms_status_pager: RTL and testbench

- Registered, paged OLED text-screen generator for the RMS scheduler. Generalises the fixed 5-task status screen to NUM_TASKS tasks.
- Captures a coherent snapshot of scheduler state when the OLED frame driver requests a frame. Renders one page of task rows plus two summary rows into the flattened ASCII buffer.
- Pages rotate automatically or on request. Tracks sticky per-task deadline misses and signals them on screen and through the background colour.

---
 rtl/rms_oled_pkg.sv | 27 ++
 rtl/hex_to_ASCII.sv | 19 +
 rtl/rms_status_pager.sv | 214 +++++++++++++++++++++
 tb/tb_rms_status_pager.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rms_oled_pkg.sv
// Shared constants and helpers for the RMS OLED status screens.
package rms_oled_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_ONE   = 8'h31;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_BANG  = 8'h21;
  localparam logic [7:0] ASCII_T     = 8'h54;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_I     = 8'h49;
  localparam logic [7:0] ASCII_M     = 8'h4D;
  localparam logic [7:0] ASCII_E     = 8'h45;
  localparam logic [7:0] ASCII_P     = 8'h50;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_W     = 8'h57;
  localparam logic [7:0] ASCII_L     = 8'h4C;

  localparam logic [7:0] COLOR_BLUE  = 8'b00000011;
  localparam logic [7:0] COLOR_RED   = 8'b11100000;
  localparam logic [7:0] COLOR_WHITE = 8'b11111111;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/hex_to_ASCII.sv
// Converts one nibble into its uppercase hexadecimal ASCII character.
module hex_to_ASCII
  import rms_oled_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  // Digit or uppercase letter selection
  always_comb begin
    o_ascii = ASCII_ZERO;
    if (i_nibble < 4'd10) begin
      o_ascii = ASCII_ZERO + {4'd0, i_nibble};
    end else begin
      o_ascii = ASCII_A + {4'd0, i_nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/rms_status_pager.sv
// Paged RMS scheduler status screen: snapshot on frame request, render one cycle later.
module rms_status_pager
  import rms_oled_pkg::*;
#(
  parameter int NUM_TASKS     = 8,
  parameter int NUM_ASCII_COL = 12,
  parameter int NUM_ASCII_ROW = 8,
  parameter int PAGE_FRAMES   = 60,
  parameter int N_COLOR_BITS  = 8
) (
  input  logic                                 i_CLK,
  input  logic                                 i_RST,
  input  logic                                 i_frame_req,
  input  logic                                 i_page_next,
  input  logic [NUM_TASKS*32-1:0]              i_task_currentPC,
  input  logic [NUM_TASKS*32-1:0]              i_task_dffN_Q,
  input  logic [NUM_TASKS-1:0]                 i_task_period_clear,
  input  logic [NUM_TASKS-1:0]                 i_task_isComplete,
  input  logic [31:0]                          i_time,
  input  logic [3:0]                           i_task_sel,
  input  logic                                 i_task_sel_WE,
  input  logic                                 i_LCM_clear,
  output logic [NUM_ASCII_COL*NUM_ASCII_ROW*8-1:0] o_ASCII,
  output logic [N_COLOR_BITS-1:0]              o_BACKGROUND_COLOR,
  output logic [N_COLOR_BITS-1:0]              o_TEXT_COLOR,
  output logic                                 o_frame_valid,
  output logic [3:0]                           o_page
);

  localparam int TPP       = NUM_ASCII_ROW - 2;
  localparam int NUM_PAGES = ceil_div(NUM_TASKS, TPP);
  localparam int DW        = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;
  localparam int RW        = NUM_ASCII_COL * 8;
  localparam int AW        = RW * NUM_ASCII_ROW;

  logic [3:0]    page_q, page_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          adv_s;
  logic [NUM_TASKS-1:0] miss_q, miss_d;

  logic [11:0] pc_in_s  [16];
  logic [11:0] dff_in_s [16];
  logic [15:0] cmp_in_s, miss_in_s, unused_in_s;
  logic        unused_time_s;

  logic        snap_vld_q;
  logic [11:0] snap_pc_q  [16];
  logic [11:0] snap_dff_q [16];
  logic [15:0] snap_cmp_q, snap_miss_q;
  logic [11:0] snap_time_q;
  logic [3:0]  snap_sel_q, snap_page_q;
  logic        snap_we_q, snap_lcm_q;

  logic [AW-1:0]           ascii_d, ascii_q;
  logic [N_COLOR_BITS-1:0] bg_q, txt_q;
  logic                    fv_q;
  logic [3:0]              opage_q;

  // Zero-pad per-task inputs to the 16-entry maximum so rows can index freely
  for (genvar g = 0; g < 16; g++) begin : g_pad
    if (g < NUM_TASKS) begin : g_on
      assign pc_in_s[g]     = i_task_currentPC[32*g +: 12];
      assign dff_in_s[g]    = i_task_dffN_Q[32*g +: 12];
      assign cmp_in_s[g]    = i_task_isComplete[g];
      assign miss_in_s[g]   = miss_q[g];
      assign unused_in_s[g] = ^{i_task_currentPC[32*g+12 +: 20], i_task_dffN_Q[32*g+12 +: 20]};
    end else begin : g_off
      assign pc_in_s[g]     = 12'd0;
      assign dff_in_s[g]    = 12'd0;
      assign cmp_in_s[g]    = 1'b0;
      assign miss_in_s[g]   = 1'b0;
      assign unused_in_s[g] = 1'b0;
    end
  end
  assign unused_time_s = ^i_time[31:12];

  // Dwell counting and page advance; a coincident rollover and page_next advance once
  always_comb begin
    dwell_d = dwell_q;
    page_d  = page_q;
    adv_s   = 1'b0;
    if (i_frame_req) begin
      if (dwell_q == DW'(PAGE_FRAMES - 1)) begin
        dwell_d = '0;
        adv_s   = 1'b1;
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end else begin
      dwell_d = dwell_q;
    end
    if (i_page_next) begin
      dwell_d = '0;
      adv_s   = 1'b1;
    end else begin
      adv_s   = adv_s;
    end
    if (adv_s) begin
      page_d = (page_q == 4'(NUM_PAGES - 1)) ? 4'd0 : page_q + 4'd1;
    end else begin
      page_d = page_q;
    end
  end

  // Sticky misses: a new miss beats a same-cycle hyperperiod clear
  assign miss_d = (miss_q & ~{NUM_TASKS{i_LCM_clear}}) | (i_task_period_clear & ~i_task_isComplete);

  // Paging, miss and pipeline-valid state
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      page_q     <= 4'd0;
      dwell_q    <= '0;
      miss_q     <= '0;
      snap_vld_q <= 1'b0;
    end else begin
      page_q     <= page_d;
      dwell_q    <= dwell_d;
      miss_q     <= miss_d;
      snap_vld_q <= i_frame_req;
    end
  end

  // Coherent snapshot taken in the request cycle
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      snap_pc_q   <= '{default: 12'd0};
      snap_dff_q  <= '{default: 12'd0};
      snap_cmp_q  <= 16'd0;
      snap_miss_q <= 16'd0;
      snap_time_q <= 12'd0;
      snap_sel_q  <= 4'd0;
      snap_page_q <= 4'd0;
      snap_we_q   <= 1'b0;
      snap_lcm_q  <= 1'b0;
    end else if (i_frame_req) begin
      snap_pc_q   <= pc_in_s;
      snap_dff_q  <= dff_in_s;
      snap_cmp_q  <= cmp_in_s;
      snap_miss_q <= miss_in_s;
      snap_time_q <= i_time[11:0];
      snap_sel_q  <= i_task_sel;
      snap_page_q <= page_q;
      snap_we_q   <= i_task_sel_WE;
      snap_lcm_q  <= i_LCM_clear;
    end
  end

  for (genvar r = 0; r < TPP; r++) begin : g_task_row
    logic [7:0] k_s;
    logic [3:0] idx_s;
    logic       on_s;
    logic [7:0] ch_s [7];
    logic [7:0] stat_s;

    assign k_s   = ({4'd0, snap_page_q} * 8'(TPP)) + 8'(r);
    assign on_s  = k_s < 8'(NUM_TASKS);
    assign idx_s = k_s[3:0];

    hex_to_ASCII u_k  (.i_nibble(idx_s),                   .o_ascii(ch_s[0]));
    hex_to_ASCII u_p2 (.i_nibble(snap_pc_q[idx_s][11:8]),  .o_ascii(ch_s[1]));
    hex_to_ASCII u_p1 (.i_nibble(snap_pc_q[idx_s][7:4]),   .o_ascii(ch_s[2]));
    hex_to_ASCII u_p0 (.i_nibble(snap_pc_q[idx_s][3:0]),   .o_ascii(ch_s[3]));
    hex_to_ASCII u_d2 (.i_nibble(snap_dff_q[idx_s][11:8]), .o_ascii(ch_s[4]));
    hex_to_ASCII u_d1 (.i_nibble(snap_dff_q[idx_s][7:4]),  .o_ascii(ch_s[5]));
    hex_to_ASCII u_d0 (.i_nibble(snap_dff_q[idx_s][3:0]),  .o_ascii(ch_s[6]));

    assign stat_s = snap_miss_q[idx_s] ? ASCII_BANG : (snap_cmp_q[idx_s] ? ASCII_ONE : ASCII_ZERO);
    assign ascii_d[AW-1-r*RW -: RW] = on_s ?
        {ASCII_T, ch_s[0], ASCII_SPACE, ch_s[1], ch_s[2], ch_s[3], ASCII_SPACE,
         ch_s[4], ch_s[5], ch_s[6], ASCII_SPACE, stat_s} :
        {NUM_ASCII_COL{ASCII_SPACE}};
  end

  logic [7:0] t2_s, t1_s, t0_s, pg_s, sel_s;
  hex_to_ASCII u_t2  (.i_nibble(snap_time_q[11:8]), .o_ascii(t2_s));
  hex_to_ASCII u_t1  (.i_nibble(snap_time_q[7:4]),  .o_ascii(t1_s));
  hex_to_ASCII u_t0  (.i_nibble(snap_time_q[3:0]),  .o_ascii(t0_s));
  hex_to_ASCII u_pg  (.i_nibble(snap_page_q),       .o_ascii(pg_s));
  hex_to_ASCII u_sel (.i_nibble(snap_sel_q),        .o_ascii(sel_s));

  assign ascii_d[AW-1-TPP*RW -: RW] =
      {ASCII_T, ASCII_I, ASCII_M, ASCII_E, ASCII_COLON, t2_s, t1_s, t0_s,
       ASCII_SPACE, ASCII_P, ASCII_COLON, pg_s};
  assign ascii_d[AW-1-(TPP+1)*RW -: RW] =
      {ASCII_S, ASCII_COLON, sel_s, ASCII_SPACE, ASCII_W, ASCII_COLON,
       (snap_we_q ? ASCII_ONE : ASCII_ZERO), ASCII_SPACE, ASCII_L, ASCII_COLON,
       (snap_lcm_q ? ASCII_ONE : ASCII_ZERO), ASCII_SPACE};

  // Render stage: publish the frame built from the snapshot
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      ascii_q <= {(AW/8){ASCII_SPACE}};
      bg_q    <= N_COLOR_BITS'(COLOR_BLUE);
      txt_q   <= N_COLOR_BITS'(COLOR_WHITE);
      fv_q    <= 1'b0;
      opage_q <= 4'd0;
    end else begin
      fv_q <= snap_vld_q;
      if (snap_vld_q) begin
        ascii_q <= ascii_d;
        bg_q    <= (|snap_miss_q) ? N_COLOR_BITS'(COLOR_RED) : N_COLOR_BITS'(COLOR_BLUE);
        txt_q   <= N_COLOR_BITS'(COLOR_WHITE);
        opage_q <= snap_page_q;
      end
    end
  end

  assign o_ASCII            = ascii_q;
  assign o_BACKGROUND_COLOR = bg_q;
  assign o_TEXT_COLOR       = txt_q;
  assign o_frame_valid      = fv_q;
  assign o_page             = opage_q;

endmodule

// File: tb/tb_rms_status_pager.sv
// Directed self-checking bench for rms_status_pager (8 tasks, 2 frames per page).
module tb_rms_status_pager;

  logic         clk = 1'b0;
  logic         rst, req, pnext, we, lcm;
  logic [255:0] pc, dff;
  logic [7:0]   pclr, cmp;
  logic [31:0]  tim;
  logic [3:0]   sel;
  wire  [767:0] ascii;
  wire  [7:0]   bg, txt;
  wire          fv;
  wire  [3:0]   page;

  int errors = 0;
  int checks = 0;
  logic [95:0]  exp_r;
  logic [767:0] spaces_r;

  rms_status_pager #(
    .NUM_TASKS(8), .NUM_ASCII_COL(12), .NUM_ASCII_ROW(8),
    .PAGE_FRAMES(2), .N_COLOR_BITS(8)
  ) dut (
    .i_CLK(clk), .i_RST(rst), .i_frame_req(req), .i_page_next(pnext),
    .i_task_currentPC(pc), .i_task_dffN_Q(dff),
    .i_task_period_clear(pclr), .i_task_isComplete(cmp),
    .i_time(tim), .i_task_sel(sel), .i_task_sel_WE(we), .i_LCM_clear(lcm),
    .o_ASCII(ascii), .o_BACKGROUND_COLOR(bg), .o_TEXT_COLOR(txt),
    .o_frame_valid(fv), .o_page(page)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] row_of(input int r);
    return ascii[767 - r*96 -: 96];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; pnext = 1'b0; pclr = 8'd0; lcm = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ascii !== spaces_r) begin errors++; $display("FAIL reset_ascii: got %h want all 20", ascii); end
    checks++; if (fv !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b want 0", fv); end
    checks++; if (page !== 4'd0) begin errors++; $display("FAIL reset_page: got %0d want 0", page); end
    checks++; if (bg !== 8'h03) begin errors++; $display("FAIL reset_bg: got %h want 03", bg); end
    checks++; if (txt !== 8'hFF) begin errors++; $display("FAIL reset_txt: got %h want ff", txt); end
  endtask

  task automatic test_basic();
    do_reset();
    pc = 256'd0; dff = 256'd0; cmp = 8'd0;
    pc[31:0]  = 32'hABCD01A3; dff[31:0]  = 32'h000000F0; cmp[0] = 1'b1;
    pc[63:32] = 32'h0000BEEF; dff[63:32] = 32'h00000C0D;
    tim = 32'h12345ABC; sel = 4'hA; we = 1'b1; lcm = 1'b0;
    repeat (6) cyc();
    req = 1'b1; cyc(); req = 1'b0;
    pc[31:0] = 32'h00000777;
    checks++; if (fv !== 1'b0) begin errors++; $display("FAIL basic_fv_n1: got %b want 0", fv); end
    cyc();
    checks++; if (fv !== 1'b1) begin errors++; $display("FAIL basic_fv_n2: got %b want 1", fv); end
    exp_r = "T0 1A3 0F0 1";
    checks++; if (row_of(0) !== exp_r) begin errors++; $display("FAIL basic_row0: got \"%s\" want \"%s\"", row_of(0), exp_r); end
    exp_r = "T1 EEF C0D 0";
    checks++; if (row_of(1) !== exp_r) begin errors++; $display("FAIL basic_row1: got \"%s\" want \"%s\"", row_of(1), exp_r); end
    exp_r = "T5 000 000 0";
    checks++; if (row_of(5) !== exp_r) begin errors++; $display("FAIL basic_row5: got \"%s\" want \"%s\"", row_of(5), exp_r); end
    exp_r = "TIME:ABC P:0";
    checks++; if (row_of(6) !== exp_r) begin errors++; $display("FAIL basic_row6: got \"%s\" want \"%s\"", row_of(6), exp_r); end
    exp_r = "S:A W:1 L:0 ";
    checks++; if (row_of(7) !== exp_r) begin errors++; $display("FAIL basic_row7: got \"%s\" want \"%s\"", row_of(7), exp_r); end
    checks++; if (bg !== 8'h03) begin errors++; $display("FAIL basic_bg: got %h want 03", bg); end
    checks++; if (page !== 4'd0) begin errors++; $display("FAIL basic_page: got %0d want 0", page); end
    cyc();
    checks++; if (fv !== 1'b0) begin errors++; $display("FAIL basic_fv_n3: got %b want 0", fv); end
    exp_r = "T0 1A3 0F0 1";
    checks++; if (row_of(0) !== exp_r) begin errors++; $display("FAIL basic_hold: got \"%s\" want \"%s\"", row_of(0), exp_r); end
  endtask

  task automatic test_auto_page();
    logic [3:0] expp [4];
    expp = '{4'd0, 4'd0, 4'd1, 4'd1};
    do_reset();
    pc = 256'd0; dff = 256'd0; cmp = 8'd0;
    pc[223:192] = 32'h000006C6; dff[223:192] = 32'h000000D6; cmp[6] = 1'b1;
    pc[255:224] = 32'h00000F07; dff[255:224] = 32'h00000007;
    for (int i = 0; i <= 4; i++) begin
      req = (i < 4);
      cyc();
      if (i >= 1) begin
        checks++; if (fv !== 1'b1) begin errors++; $display("FAIL auto_fv[%0d]: got %b want 1", i-1, fv); end
        checks++; if (page !== expp[i-1]) begin errors++; $display("FAIL auto_page[%0d]: got %0d want %0d", i-1, page, expp[i-1]); end
      end
    end
    req = 1'b0;
    exp_r = "T6 6C6 0D6 1";
    checks++; if (row_of(0) !== exp_r) begin errors++; $display("FAIL auto_row0: got \"%s\" want \"%s\"", row_of(0), exp_r); end
    exp_r = "T7 F07 007 0";
    checks++; if (row_of(1) !== exp_r) begin errors++; $display("FAIL auto_row1: got \"%s\" want \"%s\"", row_of(1), exp_r); end
    exp_r = "            ";
    for (int r = 2; r <= 5; r++) begin
      checks++; if (row_of(r) !== exp_r) begin errors++; $display("FAIL auto_blank%0d: got \"%s\" want spaces", r, row_of(r)); end
    end
    exp_r = "TIME:ABC P:1";
    checks++; if (row_of(6) !== exp_r) begin errors++; $display("FAIL auto_row6: got \"%s\" want \"%s\"", row_of(6), exp_r); end
    cyc();
    checks++; if (fv !== 1'b0) begin errors++; $display("FAIL auto_fv_end: got %b want 0", fv); end
  endtask

  task automatic test_page_wrap();
    bit         reqv [8];
    bit         nxtv [8];
    logic [3:0] expp [8];
    reqv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    nxtv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    expp = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      req   = (i < 8) ? reqv[i] : 1'b0;
      pnext = (i < 8) ? nxtv[i] : 1'b0;
      cyc();
      if (i >= 1) begin
        checks++; if (fv !== reqv[i-1]) begin errors++; $display("FAIL wrap_fv[%0d]: got %b want %b", i-1, fv, reqv[i-1]); end
        if (reqv[i-1]) begin
          checks++; if (page !== expp[i-1]) begin errors++; $display("FAIL wrap_page[%0d]: got %0d want %0d", i-1, page, expp[i-1]); end
        end
      end
    end
  endtask

  task automatic test_miss();
    do_reset();
    pc = 256'd0; dff = 256'd0; cmp = 8'd0;
    pc[127:96] = 32'h00000333; dff[127:96] = 32'h000003DD; cmp[5] = 1'b1;
    sel = 4'h3; we = 1'b0; lcm = 1'b0;
    pclr = 8'b0010_1000; cyc(); pclr = 8'd0;
    req = 1'b1; cyc(); req = 1'b0; cyc();
    exp_r = "T3 333 3DD !";
    checks++; if (row_of(3) !== exp_r) begin errors++; $display("FAIL miss_set_row3: got \"%s\" want \"%s\"", row_of(3), exp_r); end
    exp_r = "T5 000 000 1";
    checks++; if (row_of(5) !== exp_r) begin errors++; $display("FAIL miss_done_row5: got \"%s\" want \"%s\"", row_of(5), exp_r); end
    checks++; if (bg !== 8'hE0) begin errors++; $display("FAIL miss_set_bg: got %h want e0", bg); end
    lcm = 1'b1; cyc(); lcm = 1'b0;
    req = 1'b1; cyc(); req = 1'b0; cyc();
    exp_r = "T3 333 3DD 0";
    checks++; if (row_of(3) !== exp_r) begin errors++; $display("FAIL miss_clr_row3: got \"%s\" want \"%s\"", row_of(3), exp_r); end
    checks++; if (bg !== 8'h03) begin errors++; $display("FAIL miss_clr_bg: got %h want 03", bg); end
    pnext = 1'b1; cyc(); pnext = 1'b0;
    lcm = 1'b1; pclr[3] = 1'b1; req = 1'b1; cyc();
    lcm = 1'b0; pclr = 8'd0; req = 1'b0; cyc();
    exp_r = "T3 333 3DD 0";
    checks++; if (row_of(3) !== exp_r) begin errors++; $display("FAIL miss_race_row3: got \"%s\" want \"%s\"", row_of(3), exp_r); end
    exp_r = "S:3 W:0 L:1 ";
    checks++; if (row_of(7) !== exp_r) begin errors++; $display("FAIL miss_race_row7: got \"%s\" want \"%s\"", row_of(7), exp_r); end
    req = 1'b1; cyc(); req = 1'b0; cyc();
    exp_r = "T3 333 3DD !";
    checks++; if (row_of(3) !== exp_r) begin errors++; $display("FAIL miss_win_row3: got \"%s\" want \"%s\"", row_of(3), exp_r); end
    checks++; if (bg !== 8'hE0) begin errors++; $display("FAIL miss_win_bg: got %h want e0", bg); end
  endtask

  task automatic test_reset_in_flight();
    do_reset();
    req = 1'b1; cyc(); req = 1'b0;
    rst = 1'b1; cyc();
    checks++; if (fv !== 1'b0) begin errors++; $display("FAIL rif_fv_n1: got %b want 0", fv); end
    rst = 1'b0; cyc();
    checks++; if (fv !== 1'b0) begin errors++; $display("FAIL rif_fv_n2: got %b want 0", fv); end
    checks++; if (ascii !== spaces_r) begin errors++; $display("FAIL rif_ascii: got %h want all 20", ascii); end
    checks++; if (page !== 4'd0) begin errors++; $display("FAIL rif_page: got %0d want 0", page); end
  endtask

  initial begin
    spaces_r = {96{8'h20}};
    rst = 1'b1; req = 1'b0; pnext = 1'b0; pc = 256'd0; dff = 256'd0;
    pclr = 8'd0; cmp = 8'd0; tim = 32'h12345ABC; sel = 4'd0; we = 1'b0; lcm = 1'b0;
    test_reset();
    test_basic();
    test_auto_page();
    test_page_wrap();
    test_miss();
    test_reset_in_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
